gaussian_stream_3x3: RTL and testbench

//  Streaming 3x3 Gaussian smoothing filter (kernel [1 2 1;2 4 2;1 2 1]/16, rounded) for raster-order video.
//  Two internal line buffers form the 3x3 window; produces exactly IMG_W*IMG_H output pixels per frame.

---
 rtl/gaussian_stream_3x3.sv | 174 +++++++++++++++++
 tb/tb_gaussian_stream_3x3.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gaussian_stream_3x3.sv
// Streaming 3x3 Gaussian smoother ([1 2 1;2 4 2;1 2 1]/16, rounded) over raster video with two line buffers.
// Optional macro GAUSS_EDGE_REPLICATE_EN: border taps replicate the nearest pixel instead of zero padding.
module gaussian_stream_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic [DATA_W-1:0] pixel_out
);

`ifdef GAUSS_EDGE_REPLICATE_EN
  localparam bit REPLICATE = 1'b1;
`else
  localparam bit REPLICATE = 1'b0;
`endif

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(IMG_W + 2);
  localparam int SW = DATA_W + 2;
  localparam int TW = DATA_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] mid;
    logic [DATA_W-1:0] bot;
  } col_t;

  state_t            state, state_next;
  logic [CW-1:0]     in_col, pos_col, ctr_col;
  logic [RW-1:0]     in_row, pos_row, ctr_row;
  logic [FW-1:0]     flush_cnt;
  logic              accept, restart, beat, emit, kill, last_in, flush_done, primed;
  logic [DATA_W-1:0] pix;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  col_t              cur, v1, v2;
  logic              top_out, bot_out, left_out, right_out;
  logic [SW-1:0]     sum_l, sum_c, sum_r;
  logic [SW-1:0]     s1_l, s1_c, s1_r;
  logic              s1_valid, s1_sof, s1_eol;
  logic [TW-1:0]     total, rounded;

  function automatic logic [SW-1:0] col_sum(input col_t v, input logic t_out, input logic b_out);
    logic [DATA_W-1:0] t, b;
    t = t_out ? (REPLICATE ? v.mid : '0) : v.top;
    b = b_out ? (REPLICATE ? v.mid : '0) : v.bot;
    return SW'(t) + (SW'(v.mid) << 1) + SW'(b);
  endfunction

  assign accept     = in_valid & in_ready;
  assign restart    = accept & in_sof;
  assign beat       = (state == FLUSH) | (accept & (in_sof | (state == RUN)));
  assign kill       = restart & (state == RUN);
  assign emit       = beat & primed & ~restart;
  assign pos_col    = restart ? '0 : in_col;
  assign pos_row    = restart ? '0 : in_row;
  assign pix        = (state == FLUSH) ? '0 : pixel_in;
  assign last_in    = (state == RUN) & accept & ~in_sof & (pos_row == ROW_LAST) & (pos_col == COL_LAST);
  assign flush_done = (state == FLUSH) & (flush_cnt == FW'(IMG_W));

  // Column vector for this beat: rows r-2, r-1, r at the incoming column.
  assign cur = '{top: lb2[pos_col], mid: lb1[pos_col], bot: pix};

  assign top_out   = (ctr_row == '0);
  assign bot_out   = (ctr_row == ROW_LAST);
  assign left_out  = (ctr_col == '0);
  assign right_out = (ctr_col == COL_LAST);
  assign sum_c     = col_sum(v1, top_out, bot_out);
  assign sum_l     = left_out  ? (REPLICATE ? sum_c : '0) : col_sum(v2, top_out, bot_out);
  assign sum_r     = right_out ? (REPLICATE ? sum_c : '0) : col_sum(cur, top_out, bot_out);

  always_comb begin
    // NOTE: default first so no path through this block leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (restart) state_next = RUN;
      RUN:     if (restart) state_next = RUN;
               else if (last_in) state_next = FLUSH;
      FLUSH:   if (flush_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      in_col    <= '0;
      in_row    <= '0;
      ctr_col   <= '0;
      ctr_row   <= '0;
      flush_cnt <= '0;
      primed    <= 1'b0;
      v1        <= '0;
      v2        <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FLUSH);
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (beat) begin
        v1     <= cur;
        v2     <= v1;
        in_col <= (pos_col == COL_LAST) ? '0 : pos_col + 1'b1;
        if (pos_col == COL_LAST) in_row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
        else                     in_row <= pos_row;
      end
      // Outputs start once the window centre reaches (0,0), i.e. the beat after input (1,0).
      if (restart || flush_done)                          primed <= 1'b0;
      else if (beat && pos_row == RW'(1) && pos_col == '0) primed <= 1'b1;
      if (restart) begin
        ctr_col <= '0;
        ctr_row <= '0;
      end else if (emit) begin
        ctr_col <= right_out ? '0 : ctr_col + 1'b1;
        if (right_out) ctr_row <= bot_out ? '0 : ctr_row + 1'b1;
      end
    end
  end

  // NOTE: line-buffer RAM is deliberately not reset; stale rows are masked by the row counter.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb1[pos_col] <= pix;
      lb2[pos_col] <= lb1[pos_col];
    end
  end

  assign total   = TW'(s1_l) + (TW'(s1_c) << 1) + TW'(s1_r);
  assign rounded = total + TW'(8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_l      <= '0;
      s1_c      <= '0;
      s1_r      <= '0;
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      pixel_out <= '0;
    end else begin
      s1_valid  <= emit;
      s1_sof    <= emit & top_out & left_out;
      s1_eol    <= emit & right_out;
      if (emit) begin
        s1_l <= sum_l;
        s1_c <= sum_c;
        s1_r <= sum_r;
      end
      // A restart in RUN drops the old frame's result still in flight.
      out_valid <= s1_valid & ~kill;
      out_sof   <= s1_sof & ~kill;
      out_eol   <= s1_eol & ~kill;
      if (s1_valid) pixel_out <= rounded[TW-1:4];
    end
  end

endmodule

// File: tb/tb_gaussian_stream_3x3.sv
// Randomised bench for gaussian_stream_3x3 (4x3 image) against a direct 3x3 convolution model.
module tb_gaussian_stream_3x3;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sof;
  logic [DW-1:0] pixel_in;
  logic          out_valid, out_sof, out_eol;
  logic [DW-1:0] pixel_out;

  gaussian_stream_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .pixel_in(pixel_in), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
    .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frame [N];
  int got_pix [N];
  int q_pix [$];
  int q_sof [$];
  int q_eol [$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      q_pix.push_back(int'(pixel_out));
      q_sof.push_back(int'(out_sof));
      q_eol.push_back(int'(out_eol));
    end
  end

  function automatic int tap(input int r, input int c);
`ifdef GAUSS_EDGE_REPLICATE_EN
    r = (r < 0) ? 0 : (r >= H) ? H - 1 : r;
    c = (c < 0) ? 0 : (c >= W) ? W - 1 : c;
`else
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
`endif
    return frame[r * W + c];
  endfunction

  function automatic int model(input int r, input int c);
    int sum = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        sum += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * tap(r + dr, c + dc);
    return (sum + 8) / 16;
  endfunction

  task automatic send_pixel(input int v, input bit sof);
    int budget = 200;
    in_valid = 1'b1;
    in_sof   = sof;
    pixel_in = DW'(v);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_pixel(frame[i], i == 0);
    end
  endtask

  task automatic expect_frame(input string tag);
    int budget = 100;
    while (q_pix.size() < N && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, q_pix.size(), N);
    for (int i = 0; i < N && i < q_pix.size(); i++) begin
      got_pix[i] = q_pix[i];
      check($sformatf("%s_pix%0d", tag, i), q_pix[i], model(i / W, i % W));
      check($sformatf("%s_sof%0d", tag, i), q_sof[i], int'(i == 0));
      check($sformatf("%s_eol%0d", tag, i), q_eol[i], int'(i % W == W - 1));
    end
    q_pix.delete();
    q_sof.delete();
    q_eol.delete();
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 255));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; pixel_in = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_pixel_out", int'(pixel_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pixel without sof in IDLE is dropped; then a constant frame.
    send_pixel(77, 1'b0);
    for (int i = 0; i < N; i++) frame[i] = 100;
    send_frame(0);
    expect_frame("const");
`ifdef GAUSS_EDGE_REPLICATE_EN
    check("const_corner", got_pix[0], 100);
    check("const_edge", got_pix[1], 100);
`else
    check("const_corner", got_pix[0], 56);
    check("const_edge", got_pix[1], 75);
`endif
    check("const_int11", got_pix[5], 100);
    check("const_int12", got_pix[6], 100);

    for (int i = 0; i < N; i++) frame[i] = 0;
    frame[W + 1] = 255;
    send_frame(0);
    expect_frame("impulse");
    check("imp_11", got_pix[5], 64);
    check("imp_01", got_pix[1], 32);
    check("imp_10", got_pix[4], 32);
    check("imp_00", got_pix[0], 16);
    check("imp_03", got_pix[3], 0);

    for (int k = 0; k < 3; k++) begin
      random_frame();
      send_frame(0);
      expect_frame($sformatf("rnd%0d_nogap", k));
      send_frame(3);
      expect_frame($sformatf("rnd%0d_gap", k));
    end

    // Abort after six pixels; the restart follows back-to-back.
    random_frame();
    for (int i = 0; i < 6; i++) send_pixel(frame[i], i == 0);
    random_frame();
    send_frame(0);
    expect_frame("restart");

    // Reset asserted between clock edges while flushing.
    for (int i = 0; i < N; i++) frame[i] = 200;
    send_frame(0);
    check("flush_ready_low", int'(in_ready), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_in_ready", int'(in_ready), 0);
    @(negedge clk);
    q_pix.delete();
    q_sof.delete();
    q_eol.delete();
    rst_n = 1'b1;
    @(negedge clk);
    random_frame();
    send_frame(2);
    expect_frame("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
